// File: rtl/tqvp_uart_fifo_if.sv
// Register bus between the host and tqvp_uart_fifo: address/strobe/data in,
// combinational read data out.
interface tqvp_uart_fifo_if;
  logic [3:0] address;
  logic       data_write;
  logic [7:0] data_in;
  logic [7:0] data_out;

  modport master (output address, data_write, data_in, input data_out);
  modport slave  (input address, data_write, data_in, output data_out);
endinterface

// File: rtl/tqvp_uart_fifo.sv
// 8N1 UART with TX/RX byte FIFOs, programmable divisor and sticky W1C status.
// Register bus: TXDATA/RXDATA/STATUS/DIV_LO/DIV_HI/RX_COUNT/TX_COUNT.
module tqvp_uart_fifo #(
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned DEFAULT_DIV = 556
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       ui_in,
  output logic [7:0]       uo_out,
  tqvp_uart_fifo_if.slave  bus
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

  logic [7:0]    tx_mem [DEPTH];
  logic [7:0]    rx_mem [DEPTH];
  logic [PW-1:0] tx_rd, tx_wr, rx_rd, rx_wr;
  logic [CW-1:0] tx_count, rx_count;
  logic [15:0]   div_reg, eff_div;
  logic          tx_ovf, rx_ovf, frame_err;

  uart_state_t   tx_state, rx_state;
  logic          tx_line;
  logic [15:0]   tx_cnt, tx_div;
  logic [2:0]    tx_bit;
  logic [7:0]    tx_shift;

  logic          rx, rx_prev;
  logic [15:0]   rx_cnt, rx_div;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_shift;

  logic          tx_empty, tx_full, rx_empty, rx_full;
  logic          tx_push_req, rx_pop_req;
  logic          tx_push, tx_pop, rx_push, rx_pop;
  logic          tx_ovf_set, rx_ovf_set, frame_set, rx_stop_tick;
  logic [2:0]    flag_clr;
  logic          unused_pins;

  assign rx          = ui_in[7];
  assign unused_pins = ^ui_in[6:0];
  assign uo_out      = {7'b0, tx_line};
  assign eff_div     = (div_reg < 16'd4) ? 16'd4 : div_reg;

  assign tx_empty = (tx_count == '0);
  assign tx_full  = (tx_count == CW'(DEPTH));
  assign rx_empty = (rx_count == '0);
  assign rx_full  = (rx_count == CW'(DEPTH));

  assign tx_push_req = bus.data_write && (bus.address == 4'h0);
  assign rx_pop_req  = bus.data_write && (bus.address == 4'h1);
  assign flag_clr    = (bus.data_write && (bus.address == 4'h2)) ? bus.data_in[7:5] : 3'b000;

  // A full FIFO still accepts a push when a pop happens in the same cycle.
  assign tx_pop     = (tx_state == IDLE) && !tx_empty;
  assign tx_push    = tx_push_req && (!tx_full || tx_pop);
  assign tx_ovf_set = tx_push_req && tx_full && !tx_pop;

  assign rx_pop       = rx_pop_req && !rx_empty;
  assign rx_stop_tick = (rx_state == STOP) && (rx_cnt == rx_div - 16'd1);
  assign rx_push      = rx_stop_tick && rx && (!rx_full || rx_pop);
  assign rx_ovf_set   = rx_stop_tick && rx && rx_full && !rx_pop;
  assign frame_set    = rx_stop_tick && !rx;

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr] <= bus.data_in;
    if (rx_push) rx_mem[rx_wr] <= rx_shift;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_rd <= '0; tx_wr <= '0; tx_count <= '0;
      rx_rd <= '0; rx_wr <= '0; rx_count <= '0;
      tx_ovf <= 1'b0; rx_ovf <= 1'b0; frame_err <= 1'b0;
      div_reg <= 16'(DEFAULT_DIV);
    end else begin
      if (tx_push) tx_wr <= tx_wr + 1'b1;
      if (tx_pop)  tx_rd <= tx_rd + 1'b1;
      if (tx_push && !tx_pop)      tx_count <= tx_count + 1'b1;
      else if (!tx_push && tx_pop) tx_count <= tx_count - 1'b1;

      if (rx_push) rx_wr <= rx_wr + 1'b1;
      if (rx_pop)  rx_rd <= rx_rd + 1'b1;
      if (rx_push && !rx_pop)      rx_count <= rx_count + 1'b1;
      else if (!rx_push && rx_pop) rx_count <= rx_count - 1'b1;

      // Set wins over a simultaneous write-one-to-clear.
      tx_ovf    <= (tx_ovf    & ~flag_clr[0]) | tx_ovf_set;
      rx_ovf    <= (rx_ovf    & ~flag_clr[1]) | rx_ovf_set;
      frame_err <= (frame_err & ~flag_clr[2]) | frame_set;

      if (bus.data_write && bus.address == 4'h3) div_reg[7:0]  <= bus.data_in;
      if (bus.data_write && bus.address == 4'h4) div_reg[15:8] <= bus.data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state <= IDLE; tx_line <= 1'b1; tx_cnt <= '0;
      tx_div <= '0; tx_bit <= '0; tx_shift <= '0;
    end else begin
      case (tx_state)
        IDLE: if (tx_pop) begin
          tx_shift <= tx_mem[tx_rd];
          tx_line  <= 1'b0;
          tx_cnt   <= '0;
          tx_div   <= eff_div;
          tx_state <= START;
        end
        START: if (tx_cnt == tx_div - 16'd1) begin
          tx_cnt   <= '0;
          tx_line  <= tx_shift[0];
          tx_shift <= tx_shift >> 1;
          tx_bit   <= '0;
          tx_state <= DATA;
        end else tx_cnt <= tx_cnt + 16'd1;
        DATA: if (tx_cnt == tx_div - 16'd1) begin
          tx_cnt <= '0;
          if (tx_bit == 3'd7) begin
            tx_line  <= 1'b1;
            tx_state <= STOP;
          end else begin
            tx_line  <= tx_shift[0];
            tx_shift <= tx_shift >> 1;
            tx_bit   <= tx_bit + 3'd1;
          end
        end else tx_cnt <= tx_cnt + 16'd1;
        STOP: if (tx_cnt == tx_div - 16'd1) tx_state <= IDLE;
              else tx_cnt <= tx_cnt + 16'd1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state <= IDLE; rx_prev <= 1'b1; rx_cnt <= '0;
      rx_div <= '0; rx_bit <= '0; rx_shift <= '0;
    end else begin
      rx_prev <= rx;
      case (rx_state)
        IDLE: if (rx_prev && !rx) begin
          rx_cnt   <= '0;
          rx_div   <= eff_div;
          rx_state <= START;
        end
        START: if (rx_cnt == (rx_div >> 1) - 16'd1) begin
          rx_cnt <= '0;
          rx_bit <= '0;
          rx_state <= rx ? IDLE : DATA;
        end else rx_cnt <= rx_cnt + 16'd1;
        DATA: if (rx_cnt == rx_div - 16'd1) begin
          rx_cnt   <= '0;
          rx_shift <= {rx, rx_shift[7:1]};
          if (rx_bit == 3'd7) rx_state <= STOP;
          else rx_bit <= rx_bit + 3'd1;
        end else rx_cnt <= rx_cnt + 16'd1;
        STOP: if (rx_stop_tick) rx_state <= IDLE;
              else rx_cnt <= rx_cnt + 16'd1;
      endcase
    end
  end

  always_comb begin
    bus.data_out = '0;
    case (bus.address)
      4'h1: bus.data_out = rx_empty ? 8'h00 : rx_mem[rx_rd];
      4'h2: bus.data_out = {frame_err, rx_ovf, tx_ovf, (tx_state != IDLE),
                            rx_full, rx_empty, tx_full, tx_empty};
      4'h3: bus.data_out = div_reg[7:0];
      4'h4: bus.data_out = div_reg[15:8];
      4'h5: bus.data_out = 8'(rx_count);
      4'h6: bus.data_out = 8'(tx_count);
      default: bus.data_out = '0;
    endcase
  end
endmodule
